hdr_rewrite_merge: RTL

Parametrised packet/metadata merge stage that sits after the parser layer. It buffers 134b packet beats and parser metadata in two independent FIFOs. It pairs each packet with its metadata word in arrival order, then streams the packet out with the head beat rewritten under a byte mask or the whole packet dropped. It replaces the fixed MAC-swap stage with configurable rewrite, drop support, FIFO buffering and output backpressure.

---
 rtl/hdr_rewrite_merge_if.sv | 21 ++
 rtl/hdr_rewrite_merge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_rewrite_merge_if.sv
// Packet, metadata and output streams of hdr_rewrite_merge, named from the merge stage's side.
interface hdr_rewrite_merge_if;
  logic         i_pkt_valid;
  logic [133:0] i_pkt;
  logic         o_pkt_ready;
  logic         i_meta_valid;
  logic [129:0] i_meta;
  logic         o_data_valid;
  logic [133:0] o_data;
  logic         i_out_ready;

  modport master (
    output i_pkt_valid, i_pkt, i_meta_valid, i_meta, i_out_ready,
    input  o_pkt_ready, o_data_valid, o_data
  );

  modport slave (
    input  i_pkt_valid, i_pkt, i_meta_valid, i_meta, i_out_ready,
    output o_pkt_ready, o_data_valid, o_data
  );
endinterface

// File: rtl/hdr_rewrite_merge.sv
// Pairs packets with parser metadata in FIFO order; rewrites masked head bytes or drops the packet.
// Head out 2 cycles after both FIFOs go non-empty; o_data held while i_out_ready low; HDR_REWRITE_STATS_EN adds counters.
module hdr_rewrite_merge_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_vld,
  input  logic [DW-1:0] i_wr_dat,
  input  logic          i_rd_rdy,
  output logic [DW-1:0] o_rd_dat,
  output logic          o_empty,
  output logic [AW:0]   o_cnt
);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(2**AW);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign w_rd = i_rd_rdy && (r_cnt != '0);
  // A full FIFO still takes a write in the cycle it is being read.
  assign w_wr = i_wr_vld && ((r_cnt != LP_DEPTH) || w_rd);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_empty  = (r_cnt == '0);
  assign o_cnt    = r_cnt;
endmodule

module hdr_rewrite_merge #(
  parameter int          PKT_AW       = 9,
  parameter int          META_AW      = 4,
  parameter logic [15:0] REWRITE_MASK = 16'h0FFF,
  parameter int          PKT_AF_LVL   = 2**PKT_AW - 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  hdr_rewrite_merge_if.slave s_if,
  output logic               o_ovf
`ifdef HDR_REWRITE_STATS_EN
  ,
  output logic [31:0]        o_pkt_cnt,
  output logic [31:0]        o_drop_cnt
`endif
);
  typedef struct packed {
    logic [1:0]   tag;
    logic [3:0]   vld;
    logic [127:0] dat;
  } beat_t;

  typedef struct packed {
    logic         drop;
    logic         rew;
    logic [127:0] dat;
  } meta_t;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_DROP} state_t;

  localparam logic [PKT_AW:0]  LP_PKT_DEPTH  = (PKT_AW+1)'(2**PKT_AW);
  localparam logic [META_AW:0] LP_META_DEPTH = (META_AW+1)'(2**META_AW);
  localparam logic [PKT_AW:0]  LP_PKT_AF     = (PKT_AW+1)'(PKT_AF_LVL);

  beat_t            w_pkt_dat;
  logic             w_pkt_empty;
  logic [PKT_AW:0]  w_pkt_cnt;
  logic             w_pkt_pop;
  meta_t            w_meta_dat;
  logic             w_meta_empty;
  logic [META_AW:0] w_meta_cnt;
  logic             w_meta_pop;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rew;
  logic [127:0]     r_mdat;
  beat_t            r_out;
  logic             r_out_vld;
  logic             r_pkt_rdy;
  logic             r_ovf;

  beat_t            w_head;
  beat_t            w_load_dat;
  logic             w_load;
  logic             w_force_tail;
  logic             w_out_free;
  logic             w_pkt_ovf;
  logic             w_meta_ovf;

  hdr_rewrite_merge_fifo #(.DW(134), .AW(PKT_AW)) u_pkt_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_vld (s_if.i_pkt_valid),
    .i_wr_dat (s_if.i_pkt),
    .i_rd_rdy (w_pkt_pop),
    .o_rd_dat (w_pkt_dat),
    .o_empty  (w_pkt_empty),
    .o_cnt    (w_pkt_cnt)
  );

  hdr_rewrite_merge_fifo #(.DW(130), .AW(META_AW)) u_meta_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_vld (s_if.i_meta_valid),
    .i_wr_dat (s_if.i_meta),
    .i_rd_rdy (w_meta_pop),
    .o_rd_dat (w_meta_dat),
    .o_empty  (w_meta_empty),
    .o_cnt    (w_meta_cnt)
  );

  assign w_pkt_ovf  = s_if.i_pkt_valid  && (w_pkt_cnt  == LP_PKT_DEPTH)  && !w_pkt_pop;
  assign w_meta_ovf = s_if.i_meta_valid && (w_meta_cnt == LP_META_DEPTH) && !w_meta_pop;
  assign w_out_free = !r_out_vld || s_if.i_out_ready;

  always_comb begin
    w_head = w_pkt_dat;
    for (int i = 0; i < 16; i++) begin
      if (r_rew && REWRITE_MASK[i]) w_head.dat[8*i +: 8] = r_mdat[8*i +: 8];
    end
  end

  // The head beat stays at the packet FIFO front until HEAD, so an output stall needs no extra holding register.
  always_comb begin
    w_state_nxt  = r_state;
    w_pkt_pop    = 1'b0;
    w_meta_pop   = 1'b0;
    w_load       = 1'b0;
    w_load_dat   = w_pkt_dat;
    w_force_tail = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_pkt_empty && !w_meta_empty) begin
          w_meta_pop  = 1'b1;
          w_state_nxt = w_meta_dat.drop ? S_DROP : S_HEAD;
        end
      end
      S_HEAD: begin
        if (!w_pkt_empty && w_out_free) begin
          w_pkt_pop   = 1'b1;
          w_load      = 1'b1;
          w_load_dat  = w_head;
          w_state_nxt = w_pkt_dat.tag[1] ? S_IDLE : S_BODY;
        end
      end
      S_BODY: begin
        if (!w_pkt_empty && w_out_free) begin
          w_pkt_pop = 1'b1;
          w_load    = 1'b1;
          // A head with no preceding tail closes the open packet as its tail.
          if (w_pkt_dat.tag == 2'b01) begin
            w_force_tail   = 1'b1;
            w_load_dat.tag = 2'b10;
            w_state_nxt    = S_IDLE;
          end else if (w_pkt_dat.tag[1]) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (!w_pkt_empty) begin
          w_pkt_pop = 1'b1;
          if (w_pkt_dat.tag[1]) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rew     <= 1'b0;
      r_mdat    <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_pkt_rdy <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_meta_pop) begin
        r_rew  <= w_meta_dat.rew;
        r_mdat <= w_meta_dat.dat;
      end
      if (w_load) begin
        r_out     <= w_load_dat;
        r_out_vld <= 1'b1;
      end else if (s_if.i_out_ready) begin
        r_out_vld <= 1'b0;
      end
      r_pkt_rdy <= (w_pkt_cnt < LP_PKT_AF);
      if (w_pkt_ovf || w_meta_ovf || w_force_tail) r_ovf <= 1'b1;
    end
  end

  assign s_if.o_data_valid = r_out_vld;
  assign s_if.o_data       = r_out;
  assign s_if.o_pkt_ready  = r_pkt_rdy;
  assign o_ovf             = r_ovf;

`ifdef HDR_REWRITE_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_out_vld && s_if.i_out_ready && r_out.tag[1]) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (r_state == S_IDLE && w_state_nxt == S_DROP) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_drop_cnt = r_drop_cnt;
`endif
endmodule
